// File: rtl/wb_write_arbiter_if.sv
// Long-latency result channel into the write arbiter.
// A result transfers on any rising edge where lu_valid && lu_ready are both high.
interface wb_write_arbiter_if;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_reg;
    logic [31:0] lu_data;

    modport master (output lu_valid, output lu_reg, output lu_data, input lu_ready);
    modport slave  (input lu_valid, input lu_reg, input lu_data, output lu_ready);
endinterface

// File: rtl/wb_write_arbiter.sv
// Single owner of the register-file write port: pipeline writeback always wins,
// buffered long-latency results drain into idle cycles, stale results are squashed.
module wb_write_arbiter #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  MEM_WB_RegWrite,
    input  logic [4:0]            MEM_WB_WriteRegister,
    input  logic [31:0]           WB_WriteData,
    wb_write_arbiter_if.slave     lu,
    output logic                  RF_RegWrite,
    output logic [4:0]            RF_WriteRegister,
    output logic [31:0]           RF_WriteData,
    input  logic [4:0]            rs,
    input  logic [4:0]            rt,
    output logic                  rs_pending,
    output logic                  rt_pending,
    output logic [CW-1:0]         fifo_count
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0]             valid_q, valid_d;
    logic [DEPTH-1:0][4:0]        reg_q, reg_d;
    logic [DEPTH-1:0][31:0]       data_q, data_d;
    logic [AW-1:0]                wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]                rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]                count_q, count_d;
    logic                         rf_we_q, rf_we_d;
    logic [4:0]                   rf_reg_q, rf_reg_d;
    logic [31:0]                  rf_data_q, rf_data_d;

    logic pw;
    logic push_store;
    logic head_present;
    logic head_valid;
    logic pop;
    logic issue;
    logic rs_hit;
    logic rt_hit;

    assign pw           = MEM_WB_RegWrite && (MEM_WB_WriteRegister != 5'd0);
    assign lu.lu_ready  = !Reset && (count_q < CW'(DEPTH));
    // Register-0 results are accepted for flow control but never stored.
    assign push_store   = lu.lu_valid && lu.lu_ready && (lu.lu_reg != 5'd0);
    assign head_present = (count_q != '0);
    assign head_valid   = head_present && valid_q[rd_ptr_q];
    // A squashed head leaves silently even under a pipeline write; only valid heads need the port.
    assign pop          = head_present && (!head_valid || !pw);
    assign issue        = head_valid && !pw;

    always_comb begin
        valid_d   = valid_q;
        reg_d     = reg_q;
        data_d    = data_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        rf_we_d   = 1'b0;
        rf_reg_d  = rf_reg_q;
        rf_data_d = rf_data_q;

        if (pw) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[i] && (reg_q[i] == MEM_WB_WriteRegister)) begin
                    valid_d[i] = 1'b0;
                end
            end
            rf_we_d   = 1'b1;
            rf_reg_d  = MEM_WB_WriteRegister;
            rf_data_d = WB_WriteData;
        end else if (issue) begin
            rf_we_d   = 1'b1;
            rf_reg_d  = reg_q[rd_ptr_q];
            rf_data_d = data_q[rd_ptr_q];
        end

        if (pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + AW'(1);
        end

        // Applied after the squash so a same-cycle push is treated as younger.
        if (push_store) begin
            valid_d[wr_ptr_q] = 1'b1;
            reg_d[wr_ptr_q]   = lu.lu_reg;
            data_d[wr_ptr_q]  = lu.lu_data;
            wr_ptr_d          = wr_ptr_q + AW'(1);
        end

        if (push_store && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push_store && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            valid_q   <= '0;
            reg_q     <= '0;
            data_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rf_we_q   <= 1'b0;
            rf_reg_q  <= '0;
            rf_data_q <= '0;
        end else begin
            valid_q   <= valid_d;
            reg_q     <= reg_d;
            data_q    <= data_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rf_we_q   <= rf_we_d;
            rf_reg_q  <= rf_reg_d;
            rf_data_q <= rf_data_d;
        end
    end

    // Pending covers buffered results plus the write currently on the RF port.
    always_comb begin
        rs_hit = 1'b0;
        rt_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (reg_q[i] == rs)) rs_hit = 1'b1;
            if (valid_q[i] && (reg_q[i] == rt)) rt_hit = 1'b1;
        end
    end

    assign rs_pending       = (rs != 5'd0) && (rs_hit || (rf_we_q && (rf_reg_q == rs)));
    assign rt_pending       = (rt != 5'd0) && (rt_hit || (rf_we_q && (rf_reg_q == rt)));
    assign RF_RegWrite      = rf_we_q;
    assign RF_WriteRegister = rf_reg_q;
    assign RF_WriteData     = rf_data_q;
    assign fifo_count       = count_q;
endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter: every RF write is matched against an
// expected queue filled as stimulus is driven; status outputs are spot-checked.
module tb_wb_write_arbiter;
    logic        Clk;
    logic        Reset;
    logic        MEM_WB_RegWrite;
    logic [4:0]  MEM_WB_WriteRegister;
    logic [31:0] WB_WriteData;
    logic        RF_RegWrite;
    logic [4:0]  RF_WriteRegister;
    logic [31:0] RF_WriteData;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        rs_pending;
    logic        rt_pending;
    logic [2:0]  fifo_count;

    wb_write_arbiter_if lu_if ();

    wb_write_arbiter #(.DEPTH(4), .CW(3)) dut (
        .Clk                  (Clk),
        .Reset                (Reset),
        .MEM_WB_RegWrite      (MEM_WB_RegWrite),
        .MEM_WB_WriteRegister (MEM_WB_WriteRegister),
        .WB_WriteData         (WB_WriteData),
        .lu                   (lu_if),
        .RF_RegWrite          (RF_RegWrite),
        .RF_WriteRegister     (RF_WriteRegister),
        .RF_WriteData         (RF_WriteData),
        .rs                   (rs),
        .rt                   (rt),
        .rs_pending           (rs_pending),
        .rt_pending           (rt_pending),
        .fifo_count           (fifo_count)
    );

    int checks = 0;
    int errors = 0;
    logic [36:0] exp_q[$];
    logic [31:0] lu_vals[4];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [36:0] obs, input logic [36:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Any pipeline write driven this cycle must appear on the RF port next cycle.
    task automatic step();
        if (MEM_WB_RegWrite && MEM_WB_WriteRegister != 5'd0)
            exp_q.push_back({MEM_WB_WriteRegister, WB_WriteData});
        @(posedge Clk);
        #1;
    endtask

    task automatic lu_drive(input logic v, input logic [4:0] r, input logic [31:0] d);
        lu_if.lu_valid = v;
        lu_if.lu_reg   = r;
        lu_if.lu_data  = d;
    endtask

    task automatic pipe_drive(input logic we, input logic [4:0] r, input logic [31:0] d);
        MEM_WB_RegWrite      = we;
        MEM_WB_WriteRegister = r;
        WB_WriteData         = d;
    endtask

    always @(negedge Clk) begin
        if (RF_RegWrite === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL rf_unexpected: observed %0h expected no write", {RF_WriteRegister, RF_WriteData});
            end else begin
                check("rf_write", {RF_WriteRegister, RF_WriteData}, exp_q.pop_front());
            end
        end
    end

    initial begin
        Reset = 1'b1;
        rs = 5'd0;
        rt = 5'd0;
        pipe_drive(1'b0, 5'd0, 32'h0);
        lu_drive(1'b0, 5'd0, 32'h0);

        // Reset held two cycles
        step();
        check("ready_in_reset0", {36'h0, lu_if.lu_ready}, 37'h0);
        step();
        check("ready_in_reset1", {36'h0, lu_if.lu_ready}, 37'h0);
        Reset = 1'b0;
        #1;
        check("ready_after_reset", {36'h0, lu_if.lu_ready}, 37'h1);
        check("count_after_reset", {34'h0, fifo_count}, 37'h0);
        check("rfwe_after_reset", {36'h0, RF_RegWrite}, 37'h0);

        // Idle drain
        lu_drive(1'b1, 5'd5, 32'h11111111);
        exp_q.push_back({5'd5, 32'h11111111});
        step();
        lu_drive(1'b1, 5'd6, 32'h22222222);
        exp_q.push_back({5'd6, 32'h22222222});
        step();
        check("drain_r5_reg", {32'h0, RF_WriteRegister}, 37'd5);
        lu_drive(1'b0, 5'd0, 32'h0);
        step();
        check("drain_r6_reg", {32'h0, RF_WriteRegister}, 37'd6);
        check("drain_count", {34'h0, fifo_count}, 37'h0);
        step();
        check("drain_idle_we", {36'h0, RF_RegWrite}, 37'h0);

        // Pipeline priority while filling the FIFO
        pipe_drive(1'b1, 5'd8, 32'h00000888);
        for (int i = 0; i < 4; i++) begin
            lu_vals[i] = $urandom_range(32'h7fffffff, 1);
            check("fill_ready", {36'h0, lu_if.lu_ready}, 37'h1);
            lu_drive(1'b1, 5'(9 + i), lu_vals[i]);
            step();
        end
        lu_drive(1'b0, 5'd0, 32'h0);
        check("full_count", {34'h0, fifo_count}, 37'd4);
        check("full_ready", {36'h0, lu_if.lu_ready}, 37'h0);
        step();
        check("full_hold_count", {34'h0, fifo_count}, 37'd4);
        check("full_hold_reg", {32'h0, RF_WriteRegister}, 37'd8);
        pipe_drive(1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 4; i++) exp_q.push_back({5'(9 + i), lu_vals[i]});
        for (int i = 0; i < 4; i++) begin
            step();
            check("full_drain_reg", {32'h0, RF_WriteRegister}, 37'(9 + i));
        end
        check("full_drain_count", {34'h0, fifo_count}, 37'h0);
        step();

        // WAW squash of a buffered result
        pipe_drive(1'b1, 5'd1, 32'h00000001);
        lu_drive(1'b1, 5'd7, 32'h0000AAAA);
        step();
        lu_drive(1'b0, 5'd0, 32'h0);
        rs = 5'd7;
        #1;
        check("waw_pending_fifo", {36'h0, rs_pending}, 37'h1);
        pipe_drive(1'b1, 5'd7, 32'h0000BBBB);
        step();
        check("waw_pending_rf", {36'h0, rs_pending}, 37'h1);
        check("waw_squashed_count", {34'h0, fifo_count}, 37'd1);
        pipe_drive(1'b0, 5'd0, 32'h0);
        step();
        check("waw_silent_we", {36'h0, RF_RegWrite}, 37'h0);
        check("waw_count", {34'h0, fifo_count}, 37'h0);
        check("waw_pending_clear", {36'h0, rs_pending}, 37'h0);
        rs = 5'd0;

        // Squashed head leaves even while the pipeline holds the port
        pipe_drive(1'b1, 5'd1, 32'h00000002);
        lu_drive(1'b1, 5'd3, 32'h00000033);
        step();
        lu_drive(1'b0, 5'd0, 32'h0);
        pipe_drive(1'b1, 5'd3, 32'h00003333);
        step();
        check("sq_head_stored", {34'h0, fifo_count}, 37'd1);
        pipe_drive(1'b1, 5'd1, 32'h00000003);
        step();
        check("sq_head_popped", {34'h0, fifo_count}, 37'h0);
        pipe_drive(1'b0, 5'd0, 32'h0);
        step();

        // Register 0 handling
        check("zero_ready", {36'h0, lu_if.lu_ready}, 37'h1);
        lu_drive(1'b1, 5'd0, 32'hDEADBEEF);
        step();
        lu_drive(1'b0, 5'd0, 32'h0);
        check("zero_push_count", {34'h0, fifo_count}, 37'h0);
        pipe_drive(1'b1, 5'd1, 32'h00000004);
        lu_drive(1'b1, 5'd4, 32'h00004444);
        step();
        lu_drive(1'b0, 5'd0, 32'h0);
        pipe_drive(1'b1, 5'd0, 32'h0000FFFF);
        exp_q.push_back({5'd4, 32'h00004444});
        step();
        check("zero_pw_drain_we", {36'h0, RF_RegWrite}, 37'h1);
        check("zero_pw_drain_reg", {32'h0, RF_WriteRegister}, 37'd4);
        check("zero_pw_drain_count", {34'h0, fifo_count}, 37'h0);
        step();
        check("zero_pw_no_write", {36'h0, RF_RegWrite}, 37'h0);
        pipe_drive(1'b0, 5'd0, 32'h0);

        // Reset mid-operation with three entries buffered
        pipe_drive(1'b1, 5'd1, 32'h00000005);
        for (int i = 0; i < 3; i++) begin
            lu_drive(1'b1, 5'(13 + i), 32'(i + 32'hC0));
            step();
        end
        lu_drive(1'b0, 5'd0, 32'h0);
        rs = 5'd13;
        rt = 5'd14;
        #1;
        check("mid_count", {34'h0, fifo_count}, 37'd3);
        check("mid_pending", {35'h0, rs_pending, rt_pending}, 37'h3);
        pipe_drive(1'b0, 5'd0, 32'h0);
        Reset = 1'b1;
        #1;
        check("mid_ready_reset", {36'h0, lu_if.lu_ready}, 37'h0);
        step();
        Reset = 1'b0;
        #1;
        check("mid_count_clear", {34'h0, fifo_count}, 37'h0);
        check("mid_pending_clear", {35'h0, rs_pending, rt_pending}, 37'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("mid_no_write", {36'h0, RF_RegWrite}, 37'h0);
        end

        step();
        check("exp_drained", 37'(exp_q.size()), 37'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
